// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
//   div_state_e : controller states (IDLE, CALC, FIX, DONE_ST)
//   cnt_width() : iteration counter width for an N-bit divider, $clog2(N+1)
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        FIX     = 2'd2,
        DONE_ST = 2'd3
    } div_state_e;

    // CNT_W = $clog2(N+1): the counter must hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_trial_subtractor.sv
// Combinational ripple-borrow subtractor used for the restoring trial step.
//   a, b       : W-bit minuend / subtrahend
//   diff       : a - b (mod 2^W)
//   borrow_out : 1 when a < b (unsigned)
module div_trial_subtractor
    import seq_divider_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one shared N+1-bit trial subtractor is
// reused for N shift/trial-subtract iterations.
//   CLK, RST (async, active high)
//   START              : request; accepted in IDLE or DONE_ST only
//   DIVIDEND, DIVISOR  : operands, latched on the accepted START
//   BUSY               : high while iterating (and in FIX when signed)
//   DONE               : one-cycle pulse, results valid
//   QUOTIENT/REMAINDER : registered results, held until the next completion
//   DIV_BY_ZERO        : set with DONE when the latched divisor was zero
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (adds a FIX state, latency N+1).
module seq_restoring_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] DIVIDEND,
    input  logic [N-1:0] DIVISOR,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] QUOTIENT,
    output logic [N-1:0] REMAINDER,
    output logic         DIV_BY_ZERO
);

    localparam int CNT_W = cnt_width(N);

    div_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           borrow;
    logic           trial_msb_unused;
    logic [N-1:0]   step_rem;
    logic [N-1:0]   step_quo;
    logic [N-1:0]   dividend_mag;
    logic [N-1:0]   divisor_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign dividend_mag = DIVIDEND[N-1] ? (~DIVIDEND + N'(1)) : DIVIDEND;
    assign divisor_mag  = DIVISOR[N-1]  ? (~DIVISOR  + N'(1)) : DIVISOR;
`else
    assign dividend_mag = DIVIDEND;
    assign divisor_mag  = DIVISOR;
`endif

    // Bring the next dividend bit into the partial remainder, then try to
    // subtract the divisor. Borrow out means "doesn't fit": keep shifted.
    assign shifted = {rem_q, quo_q[N-1]};

    div_trial_subtractor #(.W(N + 1)) u_sub (
        .a          (shifted),
        .b          ({1'b0, dvs_q}),
        .diff       (trial),
        .borrow_out (borrow)
    );

    // When no borrow, trial < divisor < 2^N so its MSB is always zero.
    assign trial_msb_unused = trial[N];

    assign step_rem = borrow ? shifted[N-1:0] : trial[N-1:0];
    assign step_quo = {quo_q[N-2:0], ~borrow};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE_ST: begin
                state_d = IDLE;
                if (START) begin
                    dvs_d = divisor_mag;
                    if (DIVISOR == '0) begin
                        // Skip iteration entirely; report the fixed result.
                        state_d     = DONE_ST;
                        quotient_d  = '1;
                        remainder_d = DIVIDEND;
                        dbz_d       = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        state_d = CALC;
                        rem_d   = '0;
                        quo_d   = dividend_mag;
                        cnt_d   = CNT_W'(N);
                        dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_d = DIVIDEND[N-1] ^ DIVISOR[N-1];
                        neg_rem_d = DIVIDEND[N-1];
`endif
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d = FIX;
`else
                    state_d     = DONE_ST;
                    quotient_d  = step_quo;
                    remainder_d = step_rem;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIX: begin
                // -2^(N-1)/-1 wraps naturally: magnitude 2^(N-1), no negate.
                quotient_d  = neg_quo_q ? (~quo_q + N'(1)) : quo_q;
                remainder_d = neg_rem_q ? (~rem_q + N'(1)) : rem_q;
                state_d     = DONE_ST;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign BUSY        = (state_q == CALC) || (state_q == FIX);
    assign DONE        = (state_q == DONE_ST);
    assign QUOTIENT    = quotient_q;
    assign REMAINDER   = remainder_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider, N=8. Latency is measured as the
// number of rising edges after the accepting START edge before DONE is
// observed (sampled on falling edges).
module tb_seq_restoring_divider;

    localparam int N = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [N-1:0] DIVIDEND = '0;
    logic [N-1:0] DIVISOR = '0;
    logic         BUSY, DONE, DIV_BY_ZERO;
    logic [N-1:0] QUOTIENT, REMAINDER;

    int checks = 0;
    int failures = 0;
    int lat, busy_n;

    seq_restoring_divider #(.N(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Call on a falling edge; returns on the falling edge after the START edge.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        DIVIDEND = a;
        DIVISOR  = b;
        START    = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
    endtask

    // n0 = edges already elapsed since the accepting START edge.
    task automatic wait_done(input int n0, output int n, output int busy_cnt);
        n = n0;
        busy_cnt = 0;
        while (!DONE && n < 40) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            n++;
        end
        if (!DONE) chk("done_timeout", 32'(DONE), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_q",    32'(QUOTIENT), 0);
        chk("rst_r",    32'(REMAINDER), 0);
        chk("rst_dbz",  32'(DIV_BY_ZERO), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // 100 / 7 = 14 r 2
        launch(8'd100, 8'd7);
        wait_done(0, lat, busy_n);
        chk("a_lat",  32'(lat), 32'(LAT));
        chk("a_busy", 32'(busy_n), 32'(LAT));
        chk("a_q",    32'(QUOTIENT), 32'd14);
        chk("a_r",    32'(REMAINDER), 32'd2);
        chk("a_dbz",  32'(DIV_BY_ZERO), 0);
        @(negedge CLK);
        chk("a_done_pulse", 32'(DONE), 0);

        // 255 / 1 then 3 / 200 started in the DONE cycle
        // (signed: -1/1 = -1 r 0 and 3/-56 = 0 r 3, same bit patterns)
        launch(8'd255, 8'd1);
        wait_done(0, lat, busy_n);
        chk("b_q", 32'(QUOTIENT), 32'hFF);
        chk("b_r", 32'(REMAINDER), 32'd0);
        launch(8'd3, 8'd200);
        chk("b2b_busy", 32'(BUSY), 32'd1);
        wait_done(0, lat, busy_n);
        chk("c_lat", 32'(lat), 32'(LAT));
        chk("c_q",   32'(QUOTIENT), 32'd0);
        chk("c_r",   32'(REMAINDER), 32'd3);
        @(negedge CLK);

        // 5 / 0: DONE in the first cycle after the accepting edge
        launch(8'd5, 8'd0);
        wait_done(0, lat, busy_n);
        chk("z_lat", 32'(lat), 32'd0);
        chk("z_q",   32'(QUOTIENT), 32'hFF);
        chk("z_r",   32'(REMAINDER), 32'd5);
        chk("z_dbz", 32'(DIV_BY_ZERO), 32'd1);
        @(negedge CLK);

        // 200 / 9 with a START of 50/5 in the third CALC cycle (ignored)
        launch(8'd200, 8'd9);
        @(negedge CLK);
        @(negedge CLK);
        launch(8'd50, 8'd5);
        chk("i_hold_q", 32'(QUOTIENT), 32'hFF);
        chk("i_busy",   32'(BUSY), 32'd1);
        wait_done(3, lat, busy_n);
        chk("i_lat", 32'(lat), 32'(LAT));
`ifdef SEQ_DIVIDER_SIGNED_EN
        // -56 / 9 = -6 r -2
        chk("i_q", 32'(QUOTIENT), 32'hFA);
        chk("i_r", 32'(REMAINDER), 32'hFE);
`else
        chk("i_q", 32'(QUOTIENT), 32'd22);
        chk("i_r", 32'(REMAINDER), 32'd2);
`endif
        chk("i_dbz", 32'(DIV_BY_ZERO), 0);
        @(negedge CLK);

        // 99 / 4 aborted by RST in the fourth CALC cycle
        launch(8'd99, 8'd4);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("ab_busy", 32'(BUSY), 0);
        chk("ab_done", 32'(DONE), 0);
        chk("ab_q",    32'(QUOTIENT), 0);
        chk("ab_r",    32'(REMAINDER), 0);
        chk("ab_dbz",  32'(DIV_BY_ZERO), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        launch(8'd9, 8'd3);
        wait_done(0, lat, busy_n);
        chk("r_lat", 32'(lat), 32'(LAT));
        chk("r_q",   32'(QUOTIENT), 32'd3);
        chk("r_r",   32'(REMAINDER), 32'd0);
        @(negedge CLK);

`ifdef SEQ_DIVIDER_SIGNED_EN
        // -7 / 2 = -3 r -1
        launch(8'hF9, 8'h02);
        wait_done(0, lat, busy_n);
        chk("s_lat",  32'(lat), 32'(N + 1));
        chk("s_busy", 32'(busy_n), 32'(N + 1));
        chk("s_q",    32'(QUOTIENT), 32'hFD);
        chk("s_r",    32'(REMAINDER), 32'hFF);
        @(negedge CLK);
        // -128 / -1 wraps to -128 r 0
        launch(8'h80, 8'hFF);
        wait_done(0, lat, busy_n);
        chk("w_q", 32'(QUOTIENT), 32'h80);
        chk("w_r", 32'(REMAINDER), 32'h00);
        @(negedge CLK);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
